// File: rtl/sfp_acc_bank.sv
// Multi-pass psum accumulation bank between the ofifo and psum SRAM write-back.
// Saturating per-lane accumulate over cfg_npass passes, optional ReLU on drain, valid/ready on both sides.
module sfp_acc_bank #(
   parameter int col     = 8,
   parameter int psum_bw = 16,
   parameter int depth   = 16,
   parameter int aw      = 4,
   parameter int pass_bw = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     cfg_start,
   input  logic [aw:0]              cfg_npix,
   input  logic [pass_bw-1:0]       cfg_npass,
   input  logic                     cfg_relu,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [col*psum_bw-1:0]   in_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [col*psum_bw-1:0]   out_data,
   output logic                     busy,
   output logic                     done,
   output logic                     cfg_err
);

   typedef enum logic [1:0] {S_IDLE, S_ACC, S_DRAIN} state_t;
   typedef logic [col*psum_bw-1:0] vec_t;

   localparam logic [aw:0] DEPTH_W = (aw+1)'(depth);

   function automatic logic [psum_bw-1:0] sat_add(input logic [psum_bw-1:0] a, input logic [psum_bw-1:0] b);
      logic [psum_bw:0] s;
      s = {a[psum_bw-1], a} + {b[psum_bw-1], b};
      // Top two bits disagree only on overflow; the true sign picks the rail.
      if (s[psum_bw] != s[psum_bw-1])
         sat_add = s[psum_bw] ? {1'b1, {(psum_bw-1){1'b0}}} : {1'b0, {(psum_bw-1){1'b1}}};
      else
         sat_add = s[psum_bw-1:0];
   endfunction

   function automatic vec_t relu_vec(input vec_t v, input logic en);
      relu_vec = v;
      for (int i = 0; i < col; i++)
         if (en && v[i*psum_bw + psum_bw-1]) relu_vec[i*psum_bw +: psum_bw] = '0;
   endfunction

   state_t             r_state;
   logic [aw-1:0]      r_addr;
   logic [pass_bw-1:0] r_pass;
   logic [aw:0]        r_npix;
   logic [pass_bw-1:0] r_npass;
   logic               r_relu;
   logic               r_in_ready;
   logic               r_out_valid;
   logic               r_busy;
   logic               r_done;
   logic               r_cfg_err;
   vec_t               r_out_data;
   vec_t               r_buf [depth];

   logic               w_in_beat;
   logic               w_out_beat;
   logic               w_addr_last;
   logic               w_pass_last;
   logic               w_cfg_bad;
   logic [aw-1:0]      w_addr_inc;
   vec_t               w_rd_cur;
   vec_t               w_acc_vec;
   vec_t               w_first_vec;

   assign w_in_beat   = r_in_ready & in_valid;
   assign w_out_beat  = r_out_valid & out_ready;
   assign w_addr_last = ({1'b0, r_addr} == r_npix - (aw+1)'(1));
   assign w_pass_last = (r_pass == r_npass - pass_bw'(1));
   assign w_cfg_bad   = (cfg_npix == '0) || (cfg_npix > DEPTH_W) || (cfg_npass == '0);
   assign w_addr_inc  = r_addr + aw'(1);
   assign w_rd_cur    = r_buf[r_addr];

   // First pass overwrites, so stale contents from an earlier or aborted job never leak in.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      w_acc_vec = '0;
      for (int i = 0; i < col; i++) begin
         if (r_pass == '0)
            w_acc_vec[i*psum_bw +: psum_bw] = in_data[i*psum_bw +: psum_bw];
         else
            w_acc_vec[i*psum_bw +: psum_bw] = sat_add(w_rd_cur[i*psum_bw +: psum_bw],
                                                      in_data[i*psum_bw +: psum_bw]);
      end
   end

   // Entry 0 is presented on the last input beat; with npix==1 it is the value being written now.
   assign w_first_vec = (r_addr == '0) ? w_acc_vec : r_buf[0];

   // NOTE: the buffer has no reset; its contents are don't-care until pass 0 overwrites them.
   always_ff @(posedge clk) begin
      if (w_in_beat) r_buf[r_addr] <= w_acc_vec;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= S_IDLE;
         r_addr      <= '0;
         r_pass      <= '0;
         r_npix      <= '0;
         r_npass     <= '0;
         r_relu      <= 1'b0;
         r_in_ready  <= 1'b0;
         r_out_valid <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_cfg_err   <= 1'b0;
         r_out_data  <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments only, so update order never matters.
         r_done    <= 1'b0;
         r_cfg_err <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (cfg_start) begin
                  if (w_cfg_bad) begin
                     r_cfg_err <= 1'b1;
                  end else begin
                     r_npix     <= cfg_npix;
                     r_npass    <= cfg_npass;
                     r_relu     <= cfg_relu;
                     r_addr     <= '0;
                     r_pass     <= '0;
                     r_in_ready <= 1'b1;
                     r_busy     <= 1'b1;
                     r_state    <= S_ACC;
                  end
               end
            end
            S_ACC: begin
               if (w_in_beat) begin
                  if (w_addr_last) begin
                     r_addr <= '0;
                     if (w_pass_last) begin
                        r_in_ready  <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_out_data  <= relu_vec(w_first_vec, r_relu);
                        r_state     <= S_DRAIN;
                     end else begin
                        r_pass <= r_pass + pass_bw'(1);
                     end
                  end else begin
                     r_addr <= w_addr_inc;
                  end
               end
            end
            S_DRAIN: begin
               if (w_out_beat) begin
                  if (w_addr_last) begin
                     r_addr      <= '0;
                     r_out_valid <= 1'b0;
                     r_out_data  <= '0;
                     r_busy      <= 1'b0;
                     r_done      <= 1'b1;
                     r_state     <= S_IDLE;
                  end else begin
                     r_addr     <= w_addr_inc;
                     r_out_data <= relu_vec(r_buf[w_addr_inc], r_relu);
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign busy      = r_busy;
   assign done      = r_done;
   assign cfg_err   = r_cfg_err;

endmodule

// File: tb/tb_sfp_acc_bank.sv
// Directed self-checking bench for sfp_acc_bank; drives and samples on the falling clock edge.
module tb_sfp_acc_bank;

   localparam int COL = 8;
   localparam int PW  = 16;
   localparam int AW  = 4;
   localparam int PB  = 4;

   typedef logic [COL*PW-1:0] vec_t;

   logic          clk = 1'b0;
   logic          reset;
   logic          cfg_start;
   logic [AW:0]   cfg_npix;
   logic [PB-1:0] cfg_npass;
   logic          cfg_relu;
   logic          in_valid;
   logic          in_ready;
   vec_t          in_data;
   logic          out_valid;
   logic          out_ready;
   vec_t          out_data;
   logic          busy;
   logic          done;
   logic          cfg_err;

   int n_pass  = 0;
   int n_total = 0;

   sfp_acc_bank #(.col(COL), .psum_bw(PW), .depth(16), .aw(AW), .pass_bw(PB)) dut (
      .clk(clk), .reset(reset), .cfg_start(cfg_start), .cfg_npix(cfg_npix), .cfg_npass(cfg_npass),
      .cfg_relu(cfg_relu), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy),
      .done(done), .cfg_err(cfg_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input vec_t got, input vec_t exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   // lane0 = l0, lane1 = l1, all other lanes = rest
   function automatic vec_t mk(input int l0, input int l1, input int rest);
      vec_t v;
      for (int i = 0; i < COL; i++) v[i*PW +: PW] = PW'(rest);
      v[0 +: PW]  = PW'(l0);
      v[PW +: PW] = PW'(l1);
      return v;
   endfunction

   task automatic start_job(input int npix, input int npass, input logic relu);
      cfg_npix  = (AW+1)'(npix);
      cfg_npass = PB'(npass);
      cfg_relu  = relu;
      cfg_start = 1'b1;
      @(negedge clk);
      cfg_start = 1'b0;
   endtask

   task automatic send(input string tag, input vec_t v);
      int n = 0;
      in_data  = v;
      in_valid = 1'b1;
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) check({tag, "_in_timeout"}, vec_t'(in_ready), vec_t'(1));
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic recv(input string tag, input vec_t exp);
      int n = 0;
      out_ready = 1'b1;
      while (!out_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_valid"}, vec_t'(out_valid), vec_t'(1));
      check(tag, out_data, exp);
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_in_ready"},  vec_t'(in_ready),  vec_t'(0));
      check({tag, "_out_valid"}, vec_t'(out_valid), vec_t'(0));
      check({tag, "_busy"},      vec_t'(busy),      vec_t'(0));
      check({tag, "_done"},      vec_t'(done),      vec_t'(0));
      check({tag, "_cfg_err"},   vec_t'(cfg_err),   vec_t'(0));
      check({tag, "_out_data"},  out_data,          vec_t'(0));
   endtask

   task automatic check_done(input string tag);
      check({tag, "_done"},      vec_t'(done),      vec_t'(1));
      check({tag, "_busy"},      vec_t'(busy),      vec_t'(0));
      check({tag, "_out_valid"}, vec_t'(out_valid), vec_t'(0));
      @(negedge clk);
      check({tag, "_done_drop"}, vec_t'(done),      vec_t'(0));
   endtask

   task automatic bad_cfg(input string tag, input int npix, input int npass);
      start_job(npix, npass, 1'b0);
      check({tag, "_err"},  vec_t'(cfg_err), vec_t'(1));
      check({tag, "_busy"}, vec_t'(busy),    vec_t'(0));
      @(negedge clk);
      check({tag, "_err_drop"}, vec_t'(cfg_err), vec_t'(0));
   endtask

   initial begin
      reset     = 1'b0;
      cfg_start = 1'b0;
      cfg_npix  = '0;
      cfg_npass = '0;
      cfg_relu  = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;
      repeat (2) @(negedge clk);
      check_idle_outputs("reset");
      reset = 1'b1;
      @(negedge clk);

      // 1: single pass pass-through, in order
      start_job(4, 1, 1'b0);
      check("t1_in_ready", vec_t'(in_ready), vec_t'(1));
      check("t1_busy", vec_t'(busy), vec_t'(1));
      for (int i = 1; i <= 4; i++) send("t1_in", mk(i, 0, 0));
      for (int i = 1; i <= 4; i++) recv($sformatf("t1_out%0d", i), mk(i, 0, 0));
      check_done("t1");

      // 2: three passes of +10 on all lanes
      start_job(2, 3, 1'b0);
      for (int i = 0; i < 6; i++) send("t2_in", mk(10, 10, 10));
      check("t2_in_ready_fall", vec_t'(in_ready), vec_t'(0));
      check("t2_out_valid_rise", vec_t'(out_valid), vec_t'(1));
      recv("t2_out0", mk(30, 30, 30));
      recv("t2_out1", mk(30, 30, 30));
      check_done("t2");

      // 3: saturation at both rails, single-entry buffer
      start_job(1, 2, 1'b0);
      send("t3_in", mk(30000, -30000, 1));
      send("t3_in", mk(30000, -30000, 2));
      recv("t3_out", mk(32767, -32768, 3));
      check_done("t3");

      // 4: ReLU with a stalled consumer
      start_job(3, 2, 1'b1);
      send("t4_in", mk(-2, -1, 0));
      send("t4_in", mk(0, 0, 0));
      send("t4_in", mk(3, 1, 0));
      send("t4_in", mk(-3, 1, 0));
      send("t4_in", mk(0, 0, 0));
      send("t4_in", mk(4, 1, 0));
      for (int i = 0; i < 5; i++) begin
         check("t4_hold_valid", vec_t'(out_valid), vec_t'(1));
         check("t4_hold_data", out_data, mk(0, 0, 0));
         check("t4_hold_in_ready", vec_t'(in_ready), vec_t'(0));
         @(negedge clk);
      end
      recv("t4_out0", mk(0, 0, 0));
      recv("t4_out1", mk(0, 0, 0));
      recv("t4_out2", mk(7, 2, 0));
      check_done("t4");

      // 5: illegal configurations, then cfg_start while accumulating
      bad_cfg("t5_npix0", 0, 1);
      bad_cfg("t5_npix17", 17, 1);
      bad_cfg("t5_npass0", 4, 0);
      start_job(2, 1, 1'b0);
      send("t5_in", mk(11, 12, 13));
      start_job(0, 0, 1'b1);
      check("t5_mid_err", vec_t'(cfg_err), vec_t'(0));
      check("t5_mid_busy", vec_t'(busy), vec_t'(1));
      check("t5_mid_in_ready", vec_t'(in_ready), vec_t'(1));
      send("t5_in", mk(-21, 22, 23));
      recv("t5_out0", mk(11, 12, 13));
      recv("t5_out1", mk(-21, 22, 23));
      check_done("t5");

      // 6: asynchronous reset mid-accumulation, then a clean job
      start_job(4, 2, 1'b0);
      for (int i = 0; i < 3; i++) send("t6_in", mk(100, 200, 300));
      reset = 1'b0;
      #1;
      check_idle_outputs("t6_abort");
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      start_job(4, 1, 1'b0);
      for (int i = 5; i <= 8; i++) send("t6_in2", mk(i, -i, 0));
      for (int i = 5; i <= 8; i++) recv($sformatf("t6_out%0d", i), mk(i, -i, 0));
      check_done("t6");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
